// File: rtl/radiant_scaler_snapshot_pkg.sv
// Shared types and constants for the RADIANT scaler snapshot readout.
// Used by the top-level FSM and by the testbench-facing frame layout.
package radiant_scaler_snapshot_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        READ   = 2'd2,
        NEXT   = 2'd3
    } state_t;

    localparam logic [15:0] HDR_MAGIC = 16'h5CA1;
    localparam logic [31:0] ERR_WORD  = 32'hFFFFFFFF;

    // One header word followed by every scaler word.
    function automatic int frame_len(input int num_words);
        return num_words + 1;
    endfunction

endpackage

// File: rtl/radiant_scaler_snapshot_fifo.sv
// First-word-fall-through synchronous FIFO holding {tlast, data} words.
// Reports free space so the writer can reserve a whole frame up front.
module scaler_snapshot_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_free
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_wr;
    logic             w_rd;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_wr    = i_wr_en && !w_full;
    assign w_rd    = i_rd_en && !o_empty;
    assign o_free  = (AW+1)'(DEPTH) - r_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    // Stale storage is masked so the output bus reads zero while empty.
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/radiant_scaler_snapshot.sv
// Wishbone read master that copies all scaler words into a framed FIFO
// snapshot on each update strobe and streams the frames out.
module radiant_scaler_snapshot
    import radiant_scaler_snapshot_pkg::*;
#(
    parameter int          NUM_WORDS  = 16,
    parameter logic [15:0] BASE_ADR   = 16'h0800,
    parameter int          FIFO_DEPTH = 64,
    parameter int          TIMEOUT    = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trig_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [15:0] wbm_adr_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic [15:0] drop_cnt_o,
    output logic        busy_o
);

    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FRAME_WORDS = CW'(frame_len(NUM_WORDS));
    localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_WORDS - 1);
    localparam logic [TW-1:0] TMO_LIMIT   = TW'(TIMEOUT);

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_idx;
    logic [TW-1:0] r_tmo;
    logic [15:0]   r_seq;
    logic [15:0]   r_drop_cnt;
    logic          r_pend;

    logic          w_req;
    logic          w_room;
    logic          w_resp;
    logic          w_last;
    logic          w_idle_drop;
    logic          w_busy_drop;
    logic          w_push;
    logic [32:0]   w_push_data;
    logic [32:0]   w_rd_data;
    logic          w_empty;
    logic [CW-1:0] w_free;

    assign w_req  = trig_i || r_pend;
    assign w_room = (w_free >= FRAME_WORDS);
    assign w_resp = wbm_ack_i || wbm_err_i || (r_tmo == TMO_LIMIT);
    assign w_last = (r_idx == LAST_IDX);

    // A frame only starts when the whole frame fits, so none is ever cut short.
    assign w_idle_drop = (r_state == IDLE) && w_req && !w_room;
    assign w_busy_drop = (r_state != IDLE) && trig_i && r_pend;

    always_comb begin
        w_next      = r_state;
        w_push      = 1'b0;
        w_push_data = '0;
        case (r_state)
            IDLE: begin
                if (w_req && w_room) w_next = HEADER;
            end
            HEADER: begin
                w_push      = 1'b1;
                w_push_data = {1'b0, HDR_MAGIC, r_seq};
                w_next      = READ;
            end
            READ: begin
                if (w_resp) begin
                    w_push      = 1'b1;
                    w_push_data = {w_last, (wbm_ack_i && !wbm_err_i) ? wbm_dat_i : ERR_WORD};
                    w_next      = NEXT;
                end
            end
            NEXT: begin
                w_next = w_last ? IDLE : READ;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_tmo      <= '0;
            r_seq      <= '0;
            r_drop_cnt <= '0;
            r_pend     <= 1'b0;
        end else begin
            r_state <= w_next;

            if (r_state == HEADER) r_idx <= '0;
            else if (r_state == NEXT && !w_last) r_idx <= r_idx + 1'b1;

            if (r_state == READ && !w_resp) r_tmo <= r_tmo + 1'b1;
            else r_tmo <= '0;

            if ((r_state == NEXT && w_last) || w_idle_drop) r_seq <= r_seq + 1'b1;

            if ((w_idle_drop || w_busy_drop) && r_drop_cnt != 16'hFFFF)
                r_drop_cnt <= r_drop_cnt + 1'b1;

            // In IDLE the pending request is consumed; a same-cycle strobe replaces it.
            if (r_state == IDLE) r_pend <= r_pend && trig_i;
            else r_pend <= r_pend || trig_i;
        end
    end

    assign wbm_cyc_o  = (r_state == READ) || (r_state == NEXT);
    assign wbm_stb_o  = (r_state == READ);
    assign wbm_we_o   = 1'b0;
    assign wbm_sel_o  = 4'hF;
    assign wbm_adr_o  = BASE_ADR + 16'({r_idx, 2'b00});
    assign busy_o     = (r_state != IDLE);
    assign drop_cnt_o = r_drop_cnt;

    scaler_snapshot_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_wr_en   (w_push),
        .i_wr_data (w_push_data),
        .i_rd_en   (m_tready),
        .o_rd_data (w_rd_data),
        .o_empty   (w_empty),
        .o_free    (w_free)
    );

    assign m_tvalid = !w_empty;
    assign m_tdata  = w_rd_data[31:0];
    assign m_tlast  = w_rd_data[32];

endmodule

// File: tb/tb_radiant_scaler_snapshot.sv
// Self-checking bench for radiant_scaler_snapshot: Wishbone slave model,
// stream scoreboard and a frame-level reference model.
module tb_radiant_scaler_snapshot;

    localparam int          NW    = 16;
    localparam logic [15:0] BASE  = 16'h0800;
    localparam int          DEPTH = 64;
    localparam int          TMO   = 255;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        trig_i = 1'b0;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [15:0] wbm_adr_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic [15:0] drop_cnt_o;
    logic        busy_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [32:0] exp_q[$];

    // Slave response table: kind 0 ack, 1 err, 2 ack+err, 3 never answers.
    int          resp_kind [NW];
    int          resp_lat  [NW];
    logic [31:0] resp_dat  [NW];
    int          word_len  [NW];
    int          rdy_mode = 1;
    logic        stray_ack = 1'b0;

    logic [15:0] m_seq = 16'd0;
    logic [15:0] m_drop = 16'd0;
    int          m_occ = 0;

    radiant_scaler_snapshot #(
        .NUM_WORDS  (NW),
        .BASE_ADR   (BASE),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .trig_i     (trig_i),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_err_i  (wbm_err_i),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .drop_cnt_o (drop_cnt_o),
        .busy_o     (busy_o)
    );

    always #10 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected frame: header {5CA1, seq}, then each scaler word, tlast on the final one.
    task automatic model_frame();
        exp_q.push_back({1'b0, 16'h5CA1, m_seq});
        for (int i = 0; i < NW; i++)
            exp_q.push_back({(i == NW - 1), (resp_kind[i] == 0) ? resp_dat[i] : 32'hFFFFFFFF});
        m_seq++;
    endtask

    task automatic set_plain();
        for (int i = 0; i < NW; i++) begin
            resp_kind[i] = 0;
            resp_lat[i]  = 0;
            resp_dat[i]  = 32'(BASE) + 32'(4 * i);
            word_len[i]  = 0;
        end
    endtask

    task automatic pulse_trig();
        @(negedge clk_i);
        trig_i = 1'b1;
        @(negedge clk_i);
        trig_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        exp_q.delete();
        m_seq  = 16'd0;
        m_drop = 16'd0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        while ((busy_o || exp_q.size() != 0) && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        chk("quiet_busy", 64'(busy_o), 64'd0);
        chk("quiet_words_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_not_busy(input int budget);
        int n = 0;
        while (busy_o && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        chk("not_busy", 64'(busy_o), 64'd0);
    endtask

    // Wishbone slave: answers after resp_lat cycles of stb and checks each address.
    initial begin
        int idx = 0;
        int wcnt = 0;
        int k;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = 32'd0;
        forever begin
            @(negedge clk_i);
            k = (idx < NW) ? idx : NW - 1;
            if (rst_i || !wbm_cyc_o) begin
                idx = 0;
                wcnt = 0;
                wbm_ack_i = stray_ack;
                wbm_err_i = 1'b0;
                wbm_dat_i = 32'd0;
            end else if (wbm_stb_o) begin
                if (wcnt == 0) chk("wb_adr", 64'(wbm_adr_o), 64'(BASE + 16'(4 * idx)));
                if (resp_kind[k] != 3 && wcnt == resp_lat[k]) begin
                    wbm_ack_i = (resp_kind[k] != 1);
                    wbm_err_i = (resp_kind[k] != 0);
                    wbm_dat_i = resp_dat[k];
                end else begin
                    wbm_ack_i = 1'b0;
                    wbm_err_i = 1'b0;
                end
                wcnt++;
            end else begin
                word_len[k] = wcnt;
                idx++;
                wcnt = 0;
                wbm_ack_i = 1'b0;
                wbm_err_i = 1'b0;
            end
        end
    end

    // Stream sink and scoreboard: a word counts when valid and ready meet.
    initial begin
        m_tready = 1'b0;
        forever begin
            @(negedge clk_i);
            case (rdy_mode)
                0:       m_tready = 1'b0;
                1:       m_tready = 1'b1;
                default: m_tready = ($urandom_range(0, 3) != 0);
            endcase
            if (!rst_i && m_tvalid && m_tready) begin
                if (exp_q.size() == 0) chk("queued_words", 64'(exp_q.size()), 64'd1);
                else chk("stream_word", 64'({m_tlast, m_tdata}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n;
        int n;
        int k;
        int r;
        set_plain();

        // Reset values
        repeat (2) @(negedge clk_i);
        chk("rst_cyc", 64'(wbm_cyc_o), 64'd0);
        chk("rst_stb", 64'(wbm_stb_o), 64'd0);
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_tlast), 64'd0);
        chk("rst_tdata", 64'(m_tdata), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_drop", 64'(drop_cnt_o), 64'd0);
        chk("rst_we", 64'(wbm_we_o), 64'd0);
        chk("rst_sel", 64'(wbm_sel_o), 64'hF);
        rst_i = 1'b0;

        // Single frame, 1-cycle acks returning the address
        rdy_mode = 1;
        model_frame();
        pulse_trig();
        chk("hdr_busy", 64'(busy_o), 64'd1);
        chk("hdr_tvalid", 64'(m_tvalid), 64'd0);
        chk("hdr_stb", 64'(wbm_stb_o), 64'd0);
        @(negedge clk_i);
        chk("rd_cyc", 64'(wbm_cyc_o), 64'd1);
        chk("rd_stb", 64'(wbm_stb_o), 64'd1);
        chk("rd_tvalid", 64'(m_tvalid), 64'd1);
        busy_n = 2;
        n = 0;
        while (busy_o && n < 200) begin
            @(negedge clk_i);
            n++;
            if (busy_o) busy_n++;
        end
        chk("frame_busy_cycles", 64'(busy_n), 64'(2 * NW + 1));
        wait_quiet(100);

        // Two extra triggers while busy: one pending frame, one drop
        do_reset();
        model_frame();
        model_frame();
        m_drop++;
        pulse_trig();
        repeat (3) @(negedge clk_i);
        pulse_trig();
        repeat (4) @(negedge clk_i);
        pulse_trig();
        wait_quiet(400);
        chk("busy_trig_drop", 64'(drop_cnt_o), 64'(m_drop));

        // Stalled consumer: frames reserve space, the rest are dropped whole
        do_reset();
        rdy_mode = 0;
        m_occ = 0;
        for (int t = 0; t < 5; t++) begin
            if (DEPTH - m_occ >= NW + 1) begin
                model_frame();
                m_occ += NW + 1;
            end else begin
                m_drop++;
                m_seq++;
            end
            pulse_trig();
            repeat (2) @(negedge clk_i);
            wait_not_busy(200);
        end
        repeat (3) @(negedge clk_i);
        chk("bp_drop", 64'(drop_cnt_o), 64'(m_drop));
        chk("bp_tvalid", 64'(m_tvalid), 64'd1);
        rdy_mode = 1;
        wait_quiet(200);
        model_frame();
        pulse_trig();
        wait_quiet(200);

        // Error with ack on word 0, silent slave on word 3
        set_plain();
        for (int i = 0; i < NW; i++) resp_lat[i] = $urandom_range(0, 2);
        resp_kind[0] = 2;
        resp_kind[3] = 3;
        model_frame();
        pulse_trig();
        wait_quiet(1500);
        chk("tmo_len", 64'(word_len[3]), 64'(TMO + 1));
        chk("word1_len", 64'(word_len[1]), 64'(resp_lat[1] + 1));

        // Randomized sessions: random latency, errors, backpressure, retriggers
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < NW; i++) begin
                resp_lat[i] = $urandom_range(0, 3);
                r = $urandom_range(0, 9);
                resp_kind[i] = (r == 0) ? 1 : (r == 1) ? 2 : 0;
                resp_dat[i] = $urandom;
            end
            rdy_mode = 2;
            k = $urandom_range(0, 2);
            model_frame();
            if (k >= 1) model_frame();
            if (k == 2) m_drop++;
            pulse_trig();
            for (int j = 0; j < k; j++) begin
                repeat (3) @(negedge clk_i);
                pulse_trig();
            end
            wait_quiet(2000);
            chk("rand_drop", 64'(drop_cnt_o), 64'(m_drop));
        end

        // Reset in the middle of a read, with a stray ack afterwards
        set_plain();
        for (int i = 0; i < NW; i++) resp_lat[i] = 3;
        rdy_mode = 1;
        model_frame();
        pulse_trig();
        repeat (6) @(negedge clk_i);
        n = 0;
        while (!wbm_stb_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        #2 rst_i = 1'b1;
        #1;
        chk("mid_rst_cyc", 64'(wbm_cyc_o), 64'd0);
        chk("mid_rst_stb", 64'(wbm_stb_o), 64'd0);
        chk("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_tdata", 64'(m_tdata), 64'd0);
        chk("mid_rst_drop", 64'(drop_cnt_o), 64'd0);
        exp_q.delete();
        m_seq = 16'd0;
        m_drop = 16'd0;
        stray_ack = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("stray_ack_busy", 64'(busy_o), 64'd0);
        chk("stray_ack_tvalid", 64'(m_tvalid), 64'd0);
        stray_ack = 1'b0;
        set_plain();
        @(negedge clk_i);
        model_frame();
        pulse_trig();
        wait_quiet(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
